pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core (PC/IF, IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Arbitrates stall requests from ID, EX and MEM into a per-stage stall vector.
- Sequences exception and ERET flushes: freezes, flushes all stage registers (including MEM/WB) and redirects the PC.
- Sits beside the datapath; its stall/flush outputs drive every pipeline register's hold/clear inputs.

Parameters:
- EXC_VECTOR, 32'h0000_0020, handler address for all non-ERET exceptions
- RECOVER_CYCLES, 2, post-flush cycles during which new exceptions are masked (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stallreq_id  in  1  ID stage requests stall (load-use hazard)
- stallreq_ex  in  1  EX stage requests stall (multi-cycle mul/div)
- stallreq_mem  in  1  MEM stage requests stall (bus wait)
- except_valid  in  1  MEM stage reports exception/ERET this cycle
- except_type  in  4  1=int, 2=syscall, 3=invalid instr, 4=trap, 5=overflow, 6=eret; others reserved
- cp0_epc  in  32  EPC value for ERET
- stall  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB (reserved)
- flush  out  1  clear all pipeline registers to NOP/WriteDisable/ZeroWord
- new_pc  out  32  redirect target, valid when flush=1
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset, checked before any other logic: stall=6'b000000, flush=0, new_pc=32'h0, busy=0, state=IDLE, recover counter=0.
- FSM states: IDLE, FLUSH, RECOVER.
- Stall priority (combinational, same cycle as request):
  - MEM request: stall=6'b011111
  - else EX request: stall=6'b001111
  - else ID request: stall=6'b000111
  - else stall=0
- IDLE:
  - except_valid with a valid type: stall=6'b111111 combinationally, overriding all requests. The type is latched and the FSM goes to FLUSH next edge.
  - Target latched at the same edge: cp0_epc if type=6, else EXC_VECTOR.
  - Reserved except_type is ignored and treated as no exception.
- FLUSH (exactly 1 cycle):
  - flush=1, new_pc=latched target, stall=0, busy=1.
  - Stall requests are ignored.
  - Next state RECOVER; counter loads RECOVER_CYCLES-1.
- RECOVER:
  - flush=0, busy=1; normal stall arbitration applies; except_valid is ignored (pipeline holds only bubbles).
  - Counter decrements each cycle; counter=0 returns to IDLE.
- new_pc holds its last value outside FLUSH.
- Simultaneous exception and stall request: exception wins.
- Exception during an active EX stall (divider mid-op): the freeze still applies. The subsequent flush aborts the requester, which must drop stallreq_ex after flush.
- rst asserted in any state returns to IDLE with reset outputs at the next edge; no partial flush.
- Latency: except_valid to flush=1 is one clock edge.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- When defined, adds ports:
  - perf_clr  in  1  synchronous clear
  - stall_cycles  out  32  counts cycles with stall[0]=1; saturates at 32'hFFFF_FFFF
  - flush_count  out  16  counts FLUSH cycles; saturates at 16'hFFFF
- Reset and perf_clr both zero the counters; perf_clr wins over an increment in the same cycle.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared define file holds:
  - stall-vector bit indices and the three stall patterns
  - except_type codes
  - FSM state encodings (2-bit)
  - EXC_VECTOR default
- Natural sub-module: pipe_ctrl_perf, the saturating counter pair, instantiated only under PIPE_CTRL_PERF_EN.

Test Plan:
- Reset, then idle with no requests -> stall=0, flush=0, new_pc=0, busy=0.
- stallreq_id=1 alone -> stall=6'b000111; add stallreq_mem=1 in the same cycle -> stall=6'b011111.
- except_valid=1, type=5 -> that cycle stall=6'b111111; next cycle flush=1, new_pc=32'h20; then 2 RECOVER cycles with busy=1; then IDLE.
- except_valid=1, type=6, cp0_epc=32'hBFC0_0100 -> flush=1 with new_pc=32'hBFC0_0100.
- Second except_valid during RECOVER -> ignored, no second flush; rst asserted during FLUSH -> next cycle flush=0, state IDLE.
- PIPE_CTRL_PERF_EN: 10 stalled cycles -> stall_cycles=10; perf_clr together with a stall -> stall_cycles=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stall patterns, exception codes and FSM encodings
// for the pipeline sequencer and its optional perf counters.
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;

  localparam int STB_PC  = 0;
  localparam int STB_IF  = 1;
  localparam int STB_ID  = 2;
  localparam int STB_EX  = 3;
  localparam int STB_MEM = 4;
  localparam int STB_WB  = 5;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

  localparam logic [3:0] EXC_INT     = 4'd1;
  localparam logic [3:0] EXC_SYSCALL = 4'd2;
  localparam logic [3:0] EXC_INVALID = 4'd3;
  localparam logic [3:0] EXC_TRAP    = 4'd4;
  localparam logic [3:0] EXC_OVF     = 4'd5;
  localparam logic [3:0] EXC_ERET    = 4'd6;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  function automatic logic exc_type_ok(input logic [3:0] t);
    return (t >= EXC_INT) && (t <= EXC_ERET);
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// pipe_ctrl_perf: saturating stall-cycle and flush counters.
// Present only when PIPE_CTRL_PERF_EN is defined.
`ifdef PIPE_CTRL_PERF_EN
module pipe_ctrl_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        stall_pc,
  input  logic        flush_pulse,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  // clear has priority over increment; counters stick at all-ones
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_pc && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (flush_pulse && (flush_count != '1))
        flush_count <= flush_count + 16'd1;
    end
  end

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall arbitration and exception/ERET flush sequencing.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR     = EXC_VECTOR_DEF,
  parameter int          RECOVER_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stallreq_id,
  input  logic         stallreq_ex,
  input  logic         stallreq_mem,
  input  logic         except_valid,
  input  logic [3:0]   except_type,
  input  logic [31:0]  cp0_epc,
  output logic [5:0]   stall,
  output logic         flush,
  output logic [31:0]  new_pc,
  output logic         busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  input  logic         perf_clr,
  output logic [31:0]  stall_cycles,
  output logic [15:0]  flush_count
`endif
);

  localparam logic [3:0] RC_INIT = 4'(RECOVER_CYCLES - 1);

  state_t     state;
  logic [3:0] rec_cnt;
  logic       exc_take;

  // exceptions are accepted only from IDLE and only for defined codes
  always_comb begin
    exc_take = (state == ST_IDLE) && except_valid &&
               exc_type_ok(except_type);
  end

  // freeze beats any request; otherwise deepest requester wins
  always_comb begin
    stall = STALL_NONE;
    priority case (1'b1)
      rst:                 stall = STALL_NONE;
      state == ST_FLUSH:   stall = STALL_NONE;
      exc_take:            stall = STALL_ALL;
      stallreq_mem:        stall = STALL_MEM;
      stallreq_ex:         stall = STALL_EX;
      stallreq_id:         stall = STALL_ID;
      default:             stall = STALL_NONE;
    endcase
  end

  // IDLE -> FLUSH (1 cycle) -> RECOVER (masked) -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      flush   <= 1'b0;
      new_pc  <= 32'h0;
      busy    <= 1'b0;
      rec_cnt <= 4'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (exc_take) begin
            state  <= ST_FLUSH;
            flush  <= 1'b1;
            busy   <= 1'b1;
            new_pc <= (except_type == EXC_ERET) ?
                      cp0_epc : EXC_VECTOR;
          end
        end
        ST_FLUSH: begin
          state   <= ST_RECOVER;
          flush   <= 1'b0;
          busy    <= 1'b1;
          rec_cnt <= RC_INIT;
        end
        ST_RECOVER: begin
          if (rec_cnt == 4'd0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            rec_cnt <= rec_cnt - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          flush <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf u_perf (
    .clk          (clk),
    .rst          (rst),
    .clr          (perf_clr),
    .stall_pc     (stall[STB_PC]),
    .flush_pulse  (flush),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
// Perf counter steps run when PIPE_CTRL_PERF_EN is defined.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        except_valid;
  logic [3:0]  except_type;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        busy;
`ifdef PIPE_CTRL_PERF_EN
  logic        perf_clr;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  int checks;
  int failures;

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .except_valid (except_valid),
    .except_type  (except_type),
    .cp0_epc      (cp0_epc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .busy         (busy)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_clr     (perf_clr),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic fail(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    failures++;
    $error("FAIL %s observed=%0h expected=%0h",
           tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    stallreq_id = 1'b0;
    stallreq_ex = 1'b0;
    stallreq_mem = 1'b0;
    except_valid = 1'b0;
    except_type = 4'd0;
    cp0_epc = 32'h0;
`ifdef PIPE_CTRL_PERF_EN
    perf_clr = 1'b0;
`endif
    tick();
    tick();
    checks++;
    if (stall !== 6'b000000)
      fail("rst_stall", stall, 6'b000000);
    checks++;
    if (flush !== 1'b0)
      fail("rst_flush", flush, 1'b0);
    checks++;
    if (new_pc !== 32'h0)
      fail("rst_newpc", new_pc, 32'h0);
    checks++;
    if (busy !== 1'b0)
      fail("rst_busy", busy, 1'b0);

    rst = 1'b0;
    tick();
    checks++;
    if (stall !== 6'b000000)
      fail("idle_stall", stall, 6'b000000);
    checks++;
    if (busy !== 1'b0)
      fail("idle_busy", busy, 1'b0);

    stallreq_id = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b000111)
      fail("id_stall", stall, 6'b000111);
    stallreq_mem = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b011111)
      fail("mem_over_id", stall, 6'b011111);
    stallreq_id = 1'b0;
    stallreq_mem = 1'b0;
    stallreq_ex = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b001111)
      fail("ex_stall", stall, 6'b001111);

    except_valid = 1'b1;
    except_type = 4'd5;
    #1;
    checks++;
    if (stall !== 6'b111111)
      fail("exc_freeze", stall, 6'b111111);
    checks++;
    if (busy !== 1'b0)
      fail("exc_busy0", busy, 1'b0);
    tick();
    except_valid = 1'b0;
    #1;
    checks++;
    if (flush !== 1'b1)
      fail("ovf_flush", flush, 1'b1);
    checks++;
    if (new_pc !== 32'h0000_0020)
      fail("ovf_newpc", new_pc, 32'h20);
    checks++;
    if (busy !== 1'b1)
      fail("ovf_busy", busy, 1'b1);
    checks++;
    if (stall !== 6'b000000)
      fail("flush_ign_req", stall, 6'b000000);
    stallreq_ex = 1'b0;
    tick();
    checks++;
    if (flush !== 1'b0)
      fail("rec1_flush", flush, 1'b0);
    checks++;
    if (busy !== 1'b1)
      fail("rec1_busy", busy, 1'b1);
    checks++;
    if (new_pc !== 32'h0000_0020)
      fail("rec1_pc_hold", new_pc, 32'h20);
    stallreq_id = 1'b1;
    except_valid = 1'b1;
    except_type = 4'd2;
    #1;
    checks++;
    if (stall !== 6'b000111)
      fail("rec1_arb", stall, 6'b000111);
    tick();
    checks++;
    if (flush !== 1'b0)
      fail("rec2_flush", flush, 1'b0);
    checks++;
    if (busy !== 1'b1)
      fail("rec2_busy", busy, 1'b1);
    checks++;
    if (stall !== 6'b000111)
      fail("rec2_arb", stall, 6'b000111);
    except_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0)
      fail("back_idle", busy, 1'b0);
    checks++;
    if (flush !== 1'b0)
      fail("no_2nd_flush", flush, 1'b0);
    checks++;
    if (stall !== 6'b000111)
      fail("idle_id", stall, 6'b000111);
    stallreq_id = 1'b0;

    except_valid = 1'b1;
    except_type = 4'd7;
    #1;
    checks++;
    if (stall !== 6'b000000)
      fail("rsvd_stall", stall, 6'b000000);
    tick();
    checks++;
    if (flush !== 1'b0)
      fail("rsvd_flush", flush, 1'b0);
    checks++;
    if (busy !== 1'b0)
      fail("rsvd_busy", busy, 1'b0);
    except_type = 4'd0;
    #1;
    checks++;
    if (stall !== 6'b000000)
      fail("type0_stall", stall, 6'b000000);

    except_type = 4'd6;
    cp0_epc = 32'hBFC0_0100;
    #1;
    checks++;
    if (stall !== 6'b111111)
      fail("eret_freeze", stall, 6'b111111);
    tick();
    except_valid = 1'b0;
    cp0_epc = 32'h0;
    #1;
    checks++;
    if (flush !== 1'b1)
      fail("eret_flush", flush, 1'b1);
    checks++;
    if (new_pc !== 32'hBFC0_0100)
      fail("eret_newpc", new_pc, 32'hBFC0_0100);
    tick();
    tick();
    tick();
    checks++;
    if (busy !== 1'b0)
      fail("eret_idle", busy, 1'b0);
    checks++;
    if (new_pc !== 32'hBFC0_0100)
      fail("eret_pc_hold", new_pc, 32'hBFC0_0100);

    except_valid = 1'b1;
    except_type = 4'd1;
    tick();
    except_valid = 1'b0;
    checks++;
    if (flush !== 1'b1)
      fail("int_flush", flush, 1'b1);
    checks++;
    if (new_pc !== 32'h0000_0020)
      fail("int_newpc", new_pc, 32'h20);
    rst = 1'b1;
    tick();
    checks++;
    if (flush !== 1'b0)
      fail("rstf_flush", flush, 1'b0);
    checks++;
    if (busy !== 1'b0)
      fail("rstf_busy", busy, 1'b0);
    checks++;
    if (new_pc !== 32'h0)
      fail("rstf_newpc", new_pc, 32'h0);
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0)
      fail("rstf_idle_busy", busy, 1'b0);
    checks++;
    if (flush !== 1'b0)
      fail("rstf_idle_flush", flush, 1'b0);

`ifdef PIPE_CTRL_PERF_EN
    checks++;
    if (stall_cycles !== 32'd0)
      fail("perf_rst_sc", stall_cycles, 32'd0);
    checks++;
    if (flush_count !== 16'd0)
      fail("perf_rst_fc", flush_count, 32'd0);
    stallreq_id = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    stallreq_id = 1'b0;
    #1;
    checks++;
    if (stall_cycles !== 32'd10)
      fail("perf_10", stall_cycles, 32'd10);
    stallreq_mem = 1'b1;
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    stallreq_mem = 1'b0;
    checks++;
    if (stall_cycles !== 32'd0)
      fail("perf_clr_sc", stall_cycles, 32'd0);
    except_valid = 1'b1;
    except_type = 4'd3;
    tick();
    except_valid = 1'b0;
    tick();
    checks++;
    if (flush_count !== 16'd1)
      fail("perf_fc1", flush_count, 32'd1);
    checks++;
    if (stall_cycles !== 32'd1)
      fail("perf_sc_frz", stall_cycles, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
